// File: rtl/ldl_slice_arbiter.sv
`timescale 1ns/1ps
// ldl_slice_arbiter
// Time-slice round-robin arbiter. One downstream resource is shared among N
// requesters. A grant lasts until the owner drops req, or until the internal
// slice counter reaches max (>= compare), whichever comes first. At the end
// of a slice, arbitration restarts at the owner's successor, so the old
// owner is searched last. The new grant follows with no idle cycle.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   req[N]     per-requester request level
//   max[W]     slice limit; a slice lasts at most max+1 cycles (sampled live)
//   gnt[N]     registered one-hot grant, zero when idle
//   gnt_id     registered index of current owner (holds last owner when idle)
//   busy       registered, high while a grant is active
//   slice_cnt  registered cycles elapsed in the current slice
//   last       combinational: final cycle of a slice the owner still wants
module ldl_slice_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    localparam int IDW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [WIDTH-1:0] max,
    output logic [N-1:0]     gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic [WIDTH-1:0] slice_cnt,
    output logic             last
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     gnt_reg, gnt_next;
    logic [IDW-1:0]   gnt_id_reg, gnt_id_next;
    logic [IDW-1:0]   ptr_reg, ptr_next;
    logic [WIDTH-1:0] slice_cnt_reg, slice_cnt_next;

    logic [IDW-1:0]   succ;
    logic             owner_req;
    logic             expired;
    logic             slice_end;

    logic [IDW-1:0]   search_start;
    logic [2*N-1:0]   req_dbl;
    logic [2*N-1:0]   req_shift;
    logic [N-1:0]     req_rot;
    logic             win_found;
    logic [IDW-1:0]   win_off;
    logic [IDW:0]     win_sum;
    logic [IDW-1:0]   win_id;
    logic [N-1:0]     win_onehot;

    // Successor of the current owner, modulo N (N need not be a power of two).
    assign succ = (gnt_id_reg == IDW'(N - 1)) ? '0 : gnt_id_reg + IDW'(1);

    // gnt is one-hot of the owner and all-zero when idle, so this is req[owner]
    // already qualified by busy.
    assign owner_req = |(req & gnt_reg);
    assign expired   = (slice_cnt_reg >= max);
    assign slice_end = !owner_req || expired;

    // Searching from the owner's successor puts the owner itself last, which
    // is exactly the "re-grant only if nobody else wants it" rule.
    assign search_start = (state_reg == GRANT) ? succ : ptr_reg;

    // Rotate req so that bit 0 is the search start; a doubled vector makes the
    // modulo-N wrap a plain shift.
    assign req_dbl   = {req, req};
    assign req_shift = req_dbl >> search_start;
    assign req_rot   = req_shift[N-1:0];

    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_found = 1'b1;
                win_off   = IDW'(i);
            end
        end
    end

    // Map the rotated offset back to an absolute requester index.
    assign win_sum = {1'b0, search_start} + {1'b0, win_off};
    assign win_id  = (win_sum >= (IDW+1)'(N)) ? IDW'(win_sum - (IDW+1)'(N))
                                              : win_sum[IDW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == IDW'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        gnt_id_next    = gnt_id_reg;
        ptr_next       = ptr_reg;
        slice_cnt_next = slice_cnt_reg;
        case (state_reg)
            IDLE: begin
                gnt_next       = '0;
                slice_cnt_next = '0;
                if (win_found) begin
                    gnt_next    = win_onehot;
                    gnt_id_next = win_id;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (!slice_end) begin
                    // Cannot wrap: expiry ends the slice at max at the latest.
                    slice_cnt_next = slice_cnt_reg + WIDTH'(1);
                end else begin
                    ptr_next       = succ;
                    slice_cnt_next = '0;
                    if (win_found) begin
                        gnt_next    = win_onehot;
                        gnt_id_next = win_id;
                    end else begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next     = IDLE;
                gnt_next       = '0;
                slice_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= '0;
            gnt_id_reg    <= '0;
            ptr_reg       <= '0;
            slice_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_id_reg    <= gnt_id_next;
            ptr_reg       <= ptr_next;
            slice_cnt_reg <= slice_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_id    = gnt_id_reg;
    assign busy      = (state_reg == GRANT);
    assign slice_cnt = slice_cnt_reg;
    assign last      = expired && owner_req;

endmodule

// File: tb/tb_ldl_slice_arbiter.sv
`timescale 1ns/1ps
// Bench for ldl_slice_arbiter. A 4-requester instance runs the main sequence;
// a 3-requester instance (held in reset until then) runs the mid-slice reset
// sequence. Each stimulus cycle pushes its hand-computed expected outputs into
// a queue; a monitor on the falling edge pops and compares them.
module tb_ldl_slice_arbiter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    logic [7:0] max = 8'd2;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic [7:0] slice_cnt;
    logic       last;

    // N=3 instance
    logic       rst3 = 1'b1;
    logic [2:0] req3 = 3'b000;
    logic [7:0] max3 = 8'd0;
    logic [2:0] gnt3;
    logic [1:0] gnt_id3;
    logic       busy3;
    logic [7:0] slice_cnt3;
    logic       last3;

    ldl_slice_arbiter #(.N(4), .WIDTH(8)) dut4 (
        .clk(clk), .rst(rst), .req(req), .max(max),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy),
        .slice_cnt(slice_cnt), .last(last)
    );

    ldl_slice_arbiter #(.N(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .max(max3),
        .gnt(gnt3), .gnt_id(gnt_id3), .busy(busy3),
        .slice_cnt(slice_cnt3), .last(last3)
    );

    typedef struct {
        bit         sel;
        int         cyc;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic [7:0] cnt;
        logic       last;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    task automatic chk(input string name, input int cyc, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // One stimulus cycle: drive inputs just after the edge and queue the
    // outputs expected during this cycle.
    task automatic v(input bit sel, input bit r, input logic [3:0] rq,
                     input int mx, input logic [3:0] eg, input int eid,
                     input bit eb, input int ec, input bit el);
        exp_t e;
        @(posedge clk);
        #1;
        if (!sel) begin
            rst = r; req = rq; max = 8'(mx);
        end else begin
            rst3 = r; req3 = rq[2:0]; max3 = 8'(mx);
        end
        n_push++;
        e.sel = sel; e.cyc = n_push; e.gnt = eg; e.id = 2'(eid);
        e.busy = eb; e.cnt = 8'(ec); e.last = el;
        exp_q.push_back(e);
    endtask

    // Monitor: compares whatever expectation is pending, mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_pop++;
            if (!e.sel) begin
                $display("cyc %0d n4 req=%b max=%0d gnt=%b id=%0d busy=%b cnt=%0d last=%b",
                         e.cyc, req, max, gnt, gnt_id, busy, slice_cnt, last);
                chk("gnt",       e.cyc, int'(gnt),       int'(e.gnt));
                chk("gnt_id",    e.cyc, int'(gnt_id),    int'(e.id));
                chk("busy",      e.cyc, int'(busy),      int'(e.busy));
                chk("slice_cnt", e.cyc, int'(slice_cnt), int'(e.cnt));
                chk("last",      e.cyc, int'(last),      int'(e.last));
            end else begin
                $display("cyc %0d n3 req=%b max=%0d gnt=%b id=%0d busy=%b cnt=%0d last=%b",
                         e.cyc, req3, max3, gnt3, gnt_id3, busy3, slice_cnt3, last3);
                chk("gnt3",       e.cyc, int'(gnt3),       int'(e.gnt));
                chk("gnt_id3",    e.cyc, int'(gnt_id3),    int'(e.id));
                chk("busy3",      e.cyc, int'(busy3),      int'(e.busy));
                chk("slice_cnt3", e.cyc, int'(slice_cnt3), int'(e.cnt));
                chk("last3",      e.cyc, int'(last3),      int'(e.last));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        //  sel rst req     max  gnt     id busy cnt last
        // Reset held 2 cycles with all requests, then release.
        v(0, 1, 4'b1111, 2, 4'b0000, 0, 0, 0, 0);
        v(0, 1, 4'b1111, 2, 4'b0000, 0, 0, 0, 0);
        v(0, 0, 4'b1111, 2, 4'b0000, 0, 0, 0, 0);
        // Full rotation, max=2: three cycles per owner.
        for (int k = 0; k < 4; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << k;
            v(0, 0, 4'b1111, 2, oh, k, 1, 0, 0);
            v(0, 0, 4'b1111, 2, oh, k, 1, 1, 0);
            v(0, 0, 4'b1111, 2, oh, k, 1, 2, 1);
        end
        // Back to owner 0; switch to req=0100: owner 0 releases at once.
        v(0, 0, 4'b0100, 5, 4'b0001, 0, 1, 0, 0);
        // Owner 2, then drops while requester 0 rises.
        v(0, 0, 4'b0100, 5, 4'b0100, 2, 1, 0, 0);
        v(0, 0, 4'b0001, 5, 4'b0100, 2, 1, 1, 0);
        v(0, 0, 4'b0001, 5, 4'b0001, 0, 1, 0, 0);
        // Requester 0 completes; idle keeps gnt_id=0; ptr=1 picks 1 over 0,3.
        v(0, 0, 4'b0000, 5, 4'b0001, 0, 1, 1, 0);
        v(0, 0, 4'b1011, 5, 4'b0000, 0, 0, 0, 0);
        // Lone requester 1, max=3: continuous grant, count restarts.
        for (int k = 0; k < 10; k++)
            v(0, 0, 4'b0010, 3, 4'b0010, 1, 1, k % 4, (k % 4) == 3);
        // max=0 with req=1010: alternate every cycle (owner 1 at cnt 2 expires now).
        v(0, 0, 4'b1010, 0, 4'b0010, 1, 1, 2, 1);
        v(0, 0, 4'b1010, 0, 4'b1000, 3, 1, 0, 1);
        v(0, 0, 4'b1010, 0, 4'b0010, 1, 1, 0, 1);
        v(0, 0, 4'b1010, 0, 4'b1000, 3, 1, 0, 1);
        // max=7, then lowered to 1 when slice_cnt=4: moves on next cycle.
        v(0, 0, 4'b1010, 7, 4'b0010, 1, 1, 0, 0);
        v(0, 0, 4'b1010, 7, 4'b0010, 1, 1, 1, 0);
        v(0, 0, 4'b1010, 7, 4'b0010, 1, 1, 2, 0);
        v(0, 0, 4'b1010, 7, 4'b0010, 1, 1, 3, 0);
        v(0, 0, 4'b1010, 1, 4'b0010, 1, 1, 4, 1);
        v(0, 0, 4'b1010, 1, 4'b1000, 3, 1, 0, 0);
        v(0, 0, 4'b0000, 1, 4'b1000, 3, 1, 1, 0);

        // N=3: owner 2 reaches slice_cnt=3, then reset with all requesting.
        v(1, 0, 4'b0100, 5, 4'b0000, 0, 0, 0, 0);
        v(1, 0, 4'b0100, 5, 4'b0100, 2, 1, 0, 0);
        v(1, 0, 4'b0100, 5, 4'b0100, 2, 1, 1, 0);
        v(1, 0, 4'b0100, 5, 4'b0100, 2, 1, 2, 0);
        v(1, 1, 4'b0111, 5, 4'b0100, 2, 1, 3, 0);
        v(1, 0, 4'b0111, 5, 4'b0000, 0, 0, 0, 0);
        v(1, 0, 4'b0111, 5, 4'b0001, 0, 1, 0, 0);
        v(1, 0, 4'b0111, 5, 4'b0001, 0, 1, 1, 0);

        @(posedge clk);
        #1;
        chk("drained", n_push, n_pop, n_push);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
